// File: rtl/input_conditioner_array.sv
// ----------------------------------------------------------------------------
// input_conditioner_array
//
// Synchronises, debounces and edge-detects CHANNELS independent asynchronous
// inputs in a single clock domain. Each channel has a SYNC_STAGES-deep
// synchroniser, a debounce counter that must see WAIT_CYCLES consecutive
// differing synchronised samples before the conditioned level follows, and
// one-cycle edge pulses. Sticky rise/fall flags latch the pulses until
// clear_flags is asserted. A pulse arriving together with clear_flags wins.
//
// Ports:
//   clk           system clock, rising edge
//   reset         synchronous, active-high reset (clears all state)
//   noisysignal   [CHANNELS] raw asynchronous inputs
//   enable        [CHANNELS] per-channel debounce enable
//   clear_flags   clears all sticky flags
//   conditioned   [CHANNELS] debounced, synchronised level
//   positiveedge  [CHANNELS] one-cycle pulse on conditioned 0->1
//   negativeedge  [CHANNELS] one-cycle pulse on conditioned 1->0
//   rise_flag     [CHANNELS] sticky positive-edge flag
//   fall_flag     [CHANNELS] sticky negative-edge flag
//   any_edge      OR of all edge pulses
// ----------------------------------------------------------------------------
module input_conditioner_array #(
    parameter int CHANNELS    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int WAIT_CYCLES = 3,
    parameter bit RESET_LEVEL = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] noisysignal,
    input  logic [CHANNELS-1:0] enable,
    input  logic                clear_flags,
    output logic [CHANNELS-1:0] conditioned,
    output logic [CHANNELS-1:0] positiveedge,
    output logic [CHANNELS-1:0] negativeedge,
    output logic [CHANNELS-1:0] rise_flag,
    output logic [CHANNELS-1:0] fall_flag,
    output logic                any_edge
);

    localparam int CW = $clog2(WAIT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES - 1);

    logic [CHANNELS-1:0] sync_p [SYNC_STAGES];
    logic [CW-1:0]       cnt    [CHANNELS];
    logic [CHANNELS-1:0] s;

    assign s = sync_p[SYNC_STAGES-1];

    // Synchroniser stage: runs independently of enable
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_p[k] <= '0;
            end
        end else begin
            sync_p[0] <= noisysignal;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_p[k] <= sync_p[k-1];
            end
        end
    end

    // Debounce and edge stage
    always_ff @(posedge clk) begin
        if (reset) begin
            conditioned  <= {CHANNELS{RESET_LEVEL}};
            positiveedge <= '0;
            negativeedge <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                positiveedge[i] <= 1'b0;
                negativeedge[i] <= 1'b0;
                if (!enable[i] || (s[i] == conditioned[i])) begin
                    // Disabled channels and any return to the accepted level
                    // restart the stability count from zero.
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    conditioned[i]  <= s[i];
                    cnt[i]          <= '0;
                    positiveedge[i] <= s[i];
                    negativeedge[i] <= ~s[i];
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Sticky flag stage: a pulse coinciding with clear_flags still sets its bit
    always_ff @(posedge clk) begin
        if (reset) begin
            rise_flag <= '0;
            fall_flag <= '0;
        end else begin
            rise_flag <= (clear_flags ? '0 : rise_flag) | positiveedge;
            fall_flag <= (clear_flags ? '0 : fall_flag) | negativeedge;
        end
    end

    assign any_edge = |(positiveedge | negativeedge);

endmodule

// File: tb/tb_input_conditioner_array.sv
// ----------------------------------------------------------------------------
// Testbench for input_conditioner_array with default parameters.
// Directed scenarios; each task checks its own expected values inline.
// Inputs change 1 ns after a rising edge and outputs are sampled there too.
// ----------------------------------------------------------------------------
module tb_input_conditioner_array;

    logic       clk;
    logic       reset;
    logic [3:0] noisysignal;
    logic [3:0] enable;
    logic       clear_flags;
    logic [3:0] conditioned;
    logic [3:0] positiveedge;
    logic [3:0] negativeedge;
    logic [3:0] rise_flag;
    logic [3:0] fall_flag;
    logic       any_edge;

    int pass_cnt  = 0;
    int total_cnt = 0;

    input_conditioner_array #(
        .CHANNELS(4), .SYNC_STAGES(2), .WAIT_CYCLES(3), .RESET_LEVEL(1'b0)
    ) dut (
        .clk(clk), .reset(reset), .noisysignal(noisysignal), .enable(enable),
        .clear_flags(clear_flags), .conditioned(conditioned),
        .positiveedge(positiveedge), .negativeedge(negativeedge),
        .rise_flag(rise_flag), .fall_flag(fall_flag), .any_edge(any_edge)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; noisysignal = 4'hF; enable = 4'hF; clear_flags = 1'b0;
        tick(); tick();
        total_cnt++;
        if ({conditioned, positiveedge, negativeedge, rise_flag, fall_flag, any_edge} !== 21'd0)
            $display("FAIL reset_outputs: got cond=%h pe=%h ne=%h rf=%h ff=%h ae=%b, expected all 0",
                     conditioned, positiveedge, negativeedge, rise_flag, fall_flag, any_edge);
        else pass_cnt++;
        reset = 1'b0;
        for (int t = 1; t <= 4; t++) begin
            tick();
            total_cnt++;
            if (conditioned !== 4'h0 || positiveedge !== 4'h0)
                $display("FAIL reset_release_wait t=%0d: got cond=%h pe=%h, expected 0 0", t, conditioned, positiveedge);
            else pass_cnt++;
        end
        tick();
        total_cnt++;
        if (conditioned !== 4'hF || positiveedge !== 4'hF || any_edge !== 1'b1 || rise_flag !== 4'h0)
            $display("FAIL reset_release_accept: got cond=%h pe=%h ae=%b rf=%h, expected F F 1 0",
                     conditioned, positiveedge, any_edge, rise_flag);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (positiveedge !== 4'h0 || any_edge !== 1'b0 || rise_flag !== 4'hF || fall_flag !== 4'h0)
            $display("FAIL reset_release_flag: got pe=%h ae=%b rf=%h ff=%h, expected 0 0 F 0",
                     positiveedge, any_edge, rise_flag, fall_flag);
        else pass_cnt++;
    endtask

    task automatic test_bounce();
        logic [4:0] pattern;
        clear_flags = 1'b1; tick(); clear_flags = 1'b0;
        pattern = 5'b10101;
        for (int t = 0; t < 5; t++) begin
            noisysignal[0] = pattern[t];
            tick();
            total_cnt++;
            if (conditioned !== 4'hF || (positiveedge | negativeedge) !== 4'h0)
                $display("FAIL bounce_toggle t=%0d: got cond=%h pe=%h ne=%h, expected F 0 0",
                         t, conditioned, positiveedge, negativeedge);
            else pass_cnt++;
        end
        noisysignal[0] = 1'b0;
        for (int t = 1; t <= 6; t++) begin
            tick();
            total_cnt++;
            if (conditioned !== ((t < 5) ? 4'hF : 4'hE) ||
                negativeedge !== ((t == 5) ? 4'h1 : 4'h0) || positiveedge !== 4'h0)
                $display("FAIL bounce_settle t=%0d: got cond=%h ne=%h pe=%h, expected %h %h 0",
                         t, conditioned, negativeedge, positiveedge,
                         (t < 5) ? 4'hF : 4'hE, (t == 5) ? 4'h1 : 4'h0);
            else pass_cnt++;
        end
        total_cnt++;
        if (fall_flag !== 4'h1 || rise_flag !== 4'h0)
            $display("FAIL bounce_flags: got ff=%h rf=%h, expected 1 0", fall_flag, rise_flag);
        else pass_cnt++;
    endtask

    task automatic test_glitch();
        int pos_n, neg_n, pos_t, neg_t;
        noisysignal = 4'h0;
        repeat (6) tick();
        total_cnt++;
        if (conditioned !== 4'h0)
            $display("FAIL glitch_idle: got cond=%h, expected 0", conditioned);
        else pass_cnt++;
        clear_flags = 1'b1; tick(); clear_flags = 1'b0;
        noisysignal = 4'b0100; tick(); tick();
        noisysignal = 4'b0000;
        pos_n = 0;
        for (int t = 0; t < 6; t++) begin
            tick();
            if (positiveedge != 4'h0 || conditioned != 4'h0) pos_n++;
        end
        total_cnt++;
        if (pos_n !== 0 || rise_flag !== 4'h0)
            $display("FAIL glitch_short: got bad_cycles=%0d rf=%h, expected 0 0", pos_n, rise_flag);
        else pass_cnt++;
        pos_n = 0; neg_n = 0; pos_t = -1; neg_t = -1;
        for (int t = 0; t < 12; t++) begin
            noisysignal = (t < 3) ? 4'b0100 : 4'b0000;
            tick();
            if (positiveedge == 4'b0100) begin pos_n++; pos_t = t; end
            if (negativeedge == 4'b0100) begin neg_n++; neg_t = t; end
            if (t == 5) begin
                total_cnt++;
                if (conditioned !== 4'b0100)
                    $display("FAIL glitch_long_level: got cond=%h, expected 4", conditioned);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (pos_n !== 1 || neg_n !== 1 || pos_t !== 4 || neg_t !== 7)
            $display("FAIL glitch_long_pulses: got pos_n=%0d@%0d neg_n=%0d@%0d, expected 1@4 1@7",
                     pos_n, pos_t, neg_n, neg_t);
        else pass_cnt++;
        total_cnt++;
        if (rise_flag !== 4'b0100 || fall_flag !== 4'b0100 || conditioned !== 4'h0)
            $display("FAIL glitch_long_flags: got rf=%h ff=%h cond=%h, expected 4 4 0",
                     rise_flag, fall_flag, conditioned);
        else pass_cnt++;
    endtask

    task automatic test_enable();
        int bad;
        enable = 4'b1101;
        noisysignal = 4'b0010;
        bad = 0;
        for (int t = 0; t < 10; t++) begin
            tick();
            if (conditioned[1] != 1'b0 || positiveedge[1] != 1'b0) bad++;
        end
        total_cnt++;
        if (bad !== 0)
            $display("FAIL enable_hold: got bad_cycles=%0d, expected 0", bad);
        else pass_cnt++;
        enable = 4'hF;
        tick(); tick();
        total_cnt++;
        if (conditioned !== 4'h0)
            $display("FAIL enable_wait: got cond=%h, expected 0", conditioned);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (conditioned !== 4'b0010 || positiveedge !== 4'b0010 || any_edge !== 1'b1)
            $display("FAIL enable_accept: got cond=%h pe=%h ae=%b, expected 2 2 1",
                     conditioned, positiveedge, any_edge);
        else pass_cnt++;
    endtask

    task automatic test_flags();
        noisysignal = 4'b1010;
        repeat (5) tick();
        total_cnt++;
        if (positiveedge !== 4'b1000 || rise_flag !== 4'b0110 || fall_flag !== 4'b0100)
            $display("FAIL flags_pre: got pe=%h rf=%h ff=%h, expected 8 6 4",
                     positiveedge, rise_flag, fall_flag);
        else pass_cnt++;
        clear_flags = 1'b1; tick(); clear_flags = 1'b0;
        total_cnt++;
        if (rise_flag !== 4'b1000 || fall_flag !== 4'h0)
            $display("FAIL flags_set_wins: got rf=%h ff=%h, expected 8 0", rise_flag, fall_flag);
        else pass_cnt++;
        clear_flags = 1'b1; tick(); clear_flags = 1'b0;
        total_cnt++;
        if (rise_flag !== 4'h0 || fall_flag !== 4'h0)
            $display("FAIL flags_clear: got rf=%h ff=%h, expected 0 0", rise_flag, fall_flag);
        else pass_cnt++;
    endtask

    task automatic test_reset_midcount();
        int bad;
        noisysignal = 4'b1011;
        repeat (5) tick();
        total_cnt++;
        if (conditioned !== 4'b1011)
            $display("FAIL midcount_setup: got cond=%h, expected b", conditioned);
        else pass_cnt++;
        noisysignal = 4'b1010;
        repeat (4) tick();
        total_cnt++;
        if (conditioned !== 4'b1011 || negativeedge !== 4'h0)
            $display("FAIL midcount_counting: got cond=%h ne=%h, expected b 0", conditioned, negativeedge);
        else pass_cnt++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total_cnt++;
        if (conditioned !== 4'h0 || negativeedge !== 4'h0 || positiveedge !== 4'h0 || any_edge !== 1'b0)
            $display("FAIL midcount_reset: got cond=%h ne=%h pe=%h ae=%b, expected 0 0 0 0",
                     conditioned, negativeedge, positiveedge, any_edge);
        else pass_cnt++;
        noisysignal = 4'b1011;
        bad = 0;
        for (int t = 1; t <= 4; t++) begin
            tick();
            if (conditioned != 4'h0 || negativeedge != 4'h0 || positiveedge != 4'h0) bad++;
        end
        total_cnt++;
        if (bad !== 0)
            $display("FAIL midcount_restart_wait: got bad_cycles=%0d, expected 0", bad);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (conditioned !== 4'b1011 || positiveedge !== 4'b1011 || negativeedge !== 4'h0)
            $display("FAIL midcount_restart_accept: got cond=%h pe=%h ne=%h, expected b b 0",
                     conditioned, positiveedge, negativeedge);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_glitch();
        test_enable();
        test_flags();
        test_reset_midcount();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/input_conditioner_array.md
# input_conditioner_array

Multi-channel, parametrised successor to the single-bit input conditioner: synchronises, debounces and edge-detects CHANNELS independent asynchronous inputs (buttons, switches, external strobes) with configurable synchroniser depth and debounce window. Adds per-channel enables, sticky edge flags with software clear, and an any-edge summary. Sits between the top-level pins and the rest of the Lab FPGA logic, one clock domain.

## Interface
- CHANNELS, 4: number of independent input channels, 1..32.
- SYNC_STAGES, 2: synchroniser flop depth per channel, >=2.
- WAIT_CYCLES, 3: cycles a synchronised value must be stable before it is accepted, >=1.
- RESET_LEVEL, 0: value loaded into every conditioned bit at reset (0 or 1).

- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- noisysignal  input  CHANNELS  raw asynchronous inputs.
- enable  input  CHANNELS  per-channel debounce enable.
- clear_flags  input  1  clears all sticky flags.
- conditioned  output  CHANNELS  debounced, synchronised level.
- positiveedge  output  CHANNELS  one-cycle pulse on conditioned 0->1.
- negativeedge  output  CHANNELS  one-cycle pulse on conditioned 1->0.
- rise_flag  output  CHANNELS  sticky: positive edge seen since last clear.
- fall_flag  output  CHANNELS  sticky: negative edge seen since last clear.
- any_edge  output  1  OR of all positiveedge and negativeedge bits (combinational from registers).

## Operation
- Per channel i: SYNC_STAGES-deep flop chain; last stage is s[i]. Chain runs regardless of enable.
- Debounce counter cnt[i], width $clog2(WAIT_CYCLES+1), unsigned.
- Per-channel update each clk edge (reset low):
  - enable[i]=0: cnt<=0; conditioned held; edge pulses 0.
  - s==conditioned: cnt<=0; edges 0.
  - s!=conditioned and cnt==WAIT_CYCLES-1: conditioned<=s; cnt<=0; positiveedge<=s, negativeedge<=~s for that cycle.
  - s!=conditioned otherwise: cnt<=cnt+1; edges 0.
- Any return of s to conditioned before acceptance restarts the count: glitches shorter than WAIT_CYCLES synchronised cycles never reach conditioned.
- Sticky flags: rise_flag[i] set in the cycle after positiveedge[i] is high (registered OR of pulse); same for fall_flag. clear_flags=1 zeroes all flags; if a pulse and clear_flags coincide, set wins for that bit.
- Channels fully independent; simultaneous edges on several channels all reported in the same cycle.
- reset=1 (at any time, including mid-count): sync chains 0, cnt 0, conditioned = {CHANNELS{RESET_LEVEL}}, positiveedge/negativeedge 0, flags 0, any_edge 0. Reset never generates a pulse, even when it changes conditioned.
- Re-enabling a channel restarts debounce from cnt=0 against current s.

## Timing
- Input stable from before edge k: first sync flop captures at k; s valid after k+SYNC_STAGES-1; conditioned changes at edge k+SYNC_STAGES+WAIT_CYCLES-1.
- Defaults (2,3): change visible 4 edges after first sampling edge (5 if counting the edge before).
- positiveedge/negativeedge high for exactly one cycle, same cycle conditioned changes.
- rise_flag/fall_flag go high one cycle after the pulse.
- any_edge has zero added latency relative to the pulses.
- WAIT_CYCLES=1: accepted on the first cycle s differs.
- Minimum input pulse accepted: WAIT_CYCLES consecutive synchronised samples.

## Test plan
Defaults (CHANNELS=4, SYNC_STAGES=2, WAIT_CYCLES=3, RESET_LEVEL=0), 20 ns clock.
- Reset: hold reset 2 cycles with noisysignal=4'hF -> all outputs 0; release, hold inputs -> conditioned=4'hF exactly 4 edges later, positiveedge=4'hF for one cycle, any_edge=1 that cycle, rise_flag=4'hF next cycle.
- Bounce: channel 0 toggles 1,0,1,0 every cycle for 5 cycles then settles 0 -> conditioned[0] stays 1, no pulses; settling to 0 yields negativeedge[0] one cycle, 4 edges after settle.
- Glitch: 2-cycle high on channel 2 from idle -> no change, no flag; 3-cycle high -> conditioned[2] rises, later falls, one pulse each.
- Enable: enable[1]=0, drive channel 1 high 10 cycles -> conditioned[1] stays 0; set enable[1]=1 -> rises 3 edges later (sync already settled).
- Flags: clear_flags asserted in same cycle as positiveedge[3] pulse -> rise_flag[3] ends 1, other flags cleared; next clear_flags alone -> all 0.
- Reset mid-count: assert reset when cnt[0]=2 with conditioned=1 -> conditioned 0, no negativeedge pulse, counter restarts after release.
